uart_rx_deserializer: RTL and testbench

- UART receive front end. Oversamples the asynchronous serial line at 16x, validates start, data, optional parity and stop bits, and assembles bytes.
- Pushes each good byte into the downstream receive FIFO as a single-cycle write.
- Reports framing, parity and overrun errors as one-cycle pulses.

---
 rtl/uart_rx_if.sv | 7 +
 rtl/uart_rx_deserializer.sv | 85 ++++++++
 tb/tb_uart_rx_deserializer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, FIFO write port and error pulses out of the UART receiver.
interface uart_rx_if;
    logic rx, fifo_full, wr_en, frame_err, parity_err, overrun_err, busy;
    logic [7:0] wr_data;
    modport master (input rx, fifo_full, output wr_en, wr_data, frame_err, parity_err, overrun_err, busy);
    modport slave (output rx, fifo_full, input wr_en, wr_data, frame_err, parity_err, overrun_err, busy);
endinterface

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 16x oversampling UART receiver that writes good bytes to a FIFO
// and reports framing, parity and overrun errors as one-cycle pulses.
module uart_rx_deserializer #(
    parameter int BAUD_DIV = 27,
    parameter bit PARITY_EN = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input logic clk,
    input logic reset,
    uart_rx_if.master bus
);
    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic rx_m, rx_s, par;
    logic [15:0] pre;
    logic [3:0] s_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] sh;
    logic tick, mid, fin, start, par_ok, wr_n, fe_n, pe_n, ov_n;
    assign tick = pre == 16'(BAUD_DIV - 1);
    assign mid = tick && s_cnt == 4'd7;
    assign fin = tick && s_cnt == 4'd15;
    assign start = state == IDLE && !rx_s;
    assign par_ok = !PARITY_EN || ((^sh ^ par) == PARITY_ODD);
    assign bus.busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_IDLE;
        else state <= state_n;
    end
    // The stop sample decides the frame outcome in a single cycle.
    always_comb begin
        state_n = state;
        wr_n = 1'b0;
        fe_n = 1'b0;
        pe_n = 1'b0;
        ov_n = 1'b0;
        case (state)
            WAIT_IDLE: if (rx_s) state_n = IDLE;
            IDLE: if (!rx_s) state_n = START;
            START: if (mid) state_n = rx_s ? IDLE : DATA;
            DATA: if (fin && bit_cnt == 3'd7) state_n = PARITY_EN ? PARITY : STOP;
            PARITY: if (fin) state_n = STOP;
            STOP: if (fin) begin
                state_n = rx_s ? IDLE : WAIT_IDLE;
                fe_n = !rx_s;
                pe_n = rx_s && !par_ok;
                ov_n = rx_s && par_ok && bus.fifo_full;
                wr_n = rx_s && par_ok && !bus.fifo_full;
            end
            default: state_n = WAIT_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            pre <= '0;
            s_cnt <= '0;
            bit_cnt <= '0;
            sh <= '0;
            par <= 1'b0;
            bus.wr_en <= 1'b0;
            bus.wr_data <= '0;
            bus.frame_err <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.overrun_err <= 1'b0;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
            pre <= (tick || start) ? '0 : pre + 16'd1;
            s_cnt <= (start || (mid && state == START)) ? '0 : s_cnt + 4'(tick);
            if (start) bit_cnt <= '0;
            if (state == DATA && fin) begin
                sh <= {rx_s, sh[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (state == PARITY && fin) par <= rx_s;
            bus.wr_en <= wr_n;
            bus.frame_err <= fe_n;
            bus.parity_err <= pe_n;
            bus.overrun_err <= ov_n;
            if (wr_n) bus.wr_data <= sh;
        end
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: frame-level model predicts each frame outcome and its output cycle;
// every cycle both receivers (no parity / even parity) are compared against it.
module tb_uart_rx_deserializer;
    localparam int B = 2;
    localparam bit PODD = 1'b0;
    localparam int WR = 3, FE = 2, PE = 1, OV = 0;
    typedef struct {int dut; int cyc; int kind; logic [7:0] data;} ev_t;
    logic clk = 1'b0;
    logic reset;
    logic rx [2];
    logic ff [2];
    logic rst_q = 1'b1;
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int n_wr [2] = '{0, 0};
    int n_fe [2] = '{0, 0};
    int n_pe [2] = '{0, 0};
    int n_ov [2] = '{0, 0};
    int last_wr [2] = '{0, 0};
    logic [7:0] exp_data [2] = '{8'h00, 8'h00};
    logic [11:0] act [2];
    logic busy [2];
    logic [3:0] ek;
    ev_t q[$];
    int k;

    uart_rx_if if0 ();
    uart_rx_if if1 ();
    uart_rx_deserializer #(.BAUD_DIV(B)) dut0 (.clk(clk), .reset(reset), .bus(if0.master));
    uart_rx_deserializer #(.BAUD_DIV(B), .PARITY_EN(1'b1), .PARITY_ODD(PODD)) dut1 (.clk(clk), .reset(reset), .bus(if1.master));
    assign if0.rx = rx[0];
    assign if1.rx = rx[1];
    assign if0.fifo_full = ff[0];
    assign if1.fifo_full = ff[1];
    assign act[0] = {if0.wr_en, if0.frame_err, if0.parity_err, if0.overrun_err, if0.wr_data};
    assign act[1] = {if1.wr_en, if1.frame_err, if1.parity_err, if1.overrun_err, if1.wr_data};
    assign busy[0] = if0.busy;
    assign busy[1] = if1.busy;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_q <= reset;
    end

    task automatic check(input string nm, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    // Per-cycle comparison of both receivers against the expected event list.
    always @(negedge clk) begin
        if (rst_q) begin
            q.delete();
            exp_data[0] = 8'h00;
            exp_data[1] = 8'h00;
        end
        for (int d = 0; d < 2; d++) begin
            ek = 4'b0000;
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].dut == d && q[i].cyc == cyc) begin
                    ek[q[i].kind] = 1'b1;
                    if (q[i].kind == WR) exp_data[d] = q[i].data;
                    q.delete(i);
                end
            check($sformatf("dut%0d cyc%0d {wr,fe,pe,ov,data}", d, cyc), int'(act[d]), int'({ek, exp_data[d]}));
            if (act[d][11]) begin
                n_wr[d]++;
                last_wr[d] = cyc;
            end
            if (act[d][10]) n_fe[d]++;
            if (act[d][9]) n_pe[d]++;
            if (act[d][8]) n_ov[d]++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives the first `slots` bit periods of a frame; a complete frame also predicts its outcome.
    task automatic send_frame(input int d, input logic [7:0] b, input logic pb, input logic stp, input int slots, output int k0);
        int nb;
        int kind;
        logic [10:0] fr;
        nb = d == 1 ? 11 : 10;
        fr = '0;
        for (int i = 0; i < 8; i++) fr[1 + i] = b[i];
        if (d == 1) fr[9] = pb;
        fr[nb - 1] = stp;
        kind = !stp ? FE : (d == 1 && ((^b ^ pb) != PODD)) ? PE : ff[d] ? OV : WR;
        k0 = cyc;
        if (slots >= nb) q.push_back('{d, k0 + 3 + (8 + 16 * (nb - 1)) * B, kind, b});
        for (int i = 0; i < slots; i++) begin
            rx[d] = fr[i];
            step(16 * B);
        end
    endtask

    initial begin
        reset = 1'b1;
        rx[0] = 1'b1;
        rx[1] = 1'b1;
        ff[0] = 1'b0;
        ff[1] = 1'b0;
        step(3);
        check("reset busy0", int'(busy[0]), 1);
        check("reset busy1", int'(busy[1]), 1);
        reset = 1'b0;
        step(5);
        check("idle busy0", int'(busy[0]), 0);
        check("idle busy1", int'(busy[1]), 0);
        send_frame(0, 8'hA5, 1'b0, 1'b1, 10, k);
        check("A5 wr latency", last_wr[0] - k, 307);
        check("A5 data", int'(act[0][7:0]), 'hA5);
        rx[0] = 1'b0;
        step(6);
        check("glitch busy", int'(busy[0]), 1);
        rx[0] = 1'b1;
        step(40);
        check("glitch busy back", int'(busy[0]), 0);
        check("glitch no write", n_wr[0], 1);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 10, k);
        step(100);
        check("break busy", int'(busy[0]), 1);
        check("break one frame_err", n_fe[0], 1);
        rx[0] = 1'b1;
        step(10);
        check("break released busy", int'(busy[0]), 0);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 10, k);
        check("5A data", int'(act[0][7:0]), 'h5A);
        ff[0] = 1'b1;
        send_frame(0, 8'h81, 1'b0, 1'b1, 10, k);
        ff[0] = 1'b0;
        check("overrun count", n_ov[0], 1);
        check("overrun no write", n_wr[0], 2);
        send_frame(0, 8'h81, 1'b0, 1'b1, 10, k);
        check("81 write", n_wr[0], 3);
        send_frame(1, 8'h07, 1'b0, 1'b1, 11, k);
        check("parity err count", n_pe[1], 1);
        check("parity no write", n_wr[1], 0);
        send_frame(1, 8'h07, 1'b1, 1'b1, 11, k);
        check("parity wr latency", last_wr[1] - k, 339);
        check("parity data", int'(act[1][7:0]), 'h07);
        send_frame(0, 8'h00, 1'b0, 1'b1, 10, k);
        send_frame(0, 8'hFF, 1'b0, 1'b1, 10, k);
        check("b2b writes", n_wr[0], 5);
        check("b2b last data", int'(act[0][7:0]), 'hFF);
        send_frame(0, 8'hC3, 1'b0, 1'b1, 4, k);
        rx[0] = 1'b0;
        step(10);
        reset = 1'b1;
        step(3);
        rx[0] = 1'b1;
        reset = 1'b0;
        step(10);
        check("abort no write", n_wr[0], 5);
        check("abort no error", n_fe[0] + n_pe[0] + n_ov[0], 2);
        check("abort busy", int'(busy[0]), 0);
        send_frame(0, 8'h55, 1'b0, 1'b1, 10, k);
        check("55 write", n_wr[0], 6);
        check("55 data", int'(act[0][7:0]), 'h55);
        step(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
